// File: rtl/ps2_kb_command_sequencer_pkg.sv
// Shared types and PS/2 keyboard command/response byte values for the host command sequencer.
package ps2_kb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_WAIT_BAT = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;

  localparam int unsigned TIMER_W = 24;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

endpackage

// File: rtl/ps2_kb_command_sequencer_if.sv
// Byte-level link between the sequencer and the PS/2 transmitter / receive shift register.
interface ps2_kb_command_sequencer_if;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       tx_error;
  logic       rx_valid;
  logic [7:0] rx_byte;

  modport master (
    output tx_start, tx_byte,
    input  tx_done, tx_error, rx_valid, rx_byte
  );

  modport slave (
    input  tx_start, tx_byte,
    output tx_done, tx_error, rx_valid, rx_byte
  );
endinterface

// File: rtl/ps2_kb_timeout_counter.sv
// Saturating up-counter; expired is high in the cycle the count sits at limit - 1.
module ps2_kb_timeout_counter
  import ps2_kb_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {TIMER_W{1'b1}})) begin
      count_d = count_q + {{(TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == (limit - {{(TIMER_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/ps2_kb_command_sequencer.sv
// Host-to-keyboard command sequencer: arbitrates reset/LED requests, sends bytes, handles ACK/resend/BAT.
// States: IDLE wait grant | SEND pulse tx_start | WAIT_TX await transmitter | WAIT_ACK await FA/FE | WAIT_BAT await AA/FC | FINISH done pulse
module ps2_kb_command_sequencer
  import ps2_kb_pkg::*;
#(
  parameter logic [23:0] ack_timeout = 24'd100000,
  parameter logic [23:0] bat_timeout = 24'd16000000,
  parameter logic [1:0]  max_retry   = 2'd3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_reset_req,
  input  logic       led_req,
  input  logic [2:0] led_state,
  output logic       kb_reset_done,
  output logic       led_done,
  output logic       error,
  output logic       busy,
  output logic       rx_swallow,
  ps2_kb_command_sequencer_if.master bus
);

  state_e     state_q, state_d;
  logic       pending_rst_q, pending_rst_d;
  logic       pending_led_q, pending_led_d;
  logic       cmd_rst_q, cmd_rst_d;
  logic       arg_phase_q, arg_phase_d;
  logic [2:0] led_snap_q, led_snap_d;
  logic [1:0] retry_q, retry_d;
  logic       error_q, error_d;
  logic [7:0] tx_byte_q, tx_byte_d;

  logic         fail;
  logic         timer_en;
  logic         timer_clear;
  logic [23:0]  timer_limit;
  logic         timer_expired;

  ps2_kb_timeout_counter u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    pending_rst_d = pending_rst_q | kb_reset_req;
    pending_led_d = pending_led_q | led_req;
    cmd_rst_d     = cmd_rst_q;
    arg_phase_d   = arg_phase_q;
    led_snap_d    = led_snap_q;
    retry_d       = retry_q;
    error_d       = error_q;
    tx_byte_d     = tx_byte_q;
    fail          = 1'b0;
    timer_en      = 1'b0;
    timer_limit   = ack_timeout;

    case (state_q)
      ST_IDLE: begin
        if (pending_rst_q) begin
          pending_rst_d = kb_reset_req;
          cmd_rst_d     = 1'b1;
          arg_phase_d   = 1'b0;
          retry_d       = 2'd0;
          tx_byte_d     = CMD_RESET;
          state_d       = ST_SEND;
        end else if (pending_led_q) begin
          pending_led_d = led_req;
          cmd_rst_d     = 1'b0;
          arg_phase_d   = 1'b0;
          retry_d       = 2'd0;
          led_snap_d    = led_state;
          tx_byte_d     = CMD_SET_LED;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        // tx_error takes precedence when both strobes land together
        if (bus.tx_error)     fail    = 1'b1;
        else if (bus.tx_done) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        timer_en = 1'b1;
        if (bus.rx_valid && (bus.rx_byte == RSP_ACK)) begin
          retry_d = 2'd0;
          if (cmd_rst_q) begin
            state_d = ST_WAIT_BAT;
          end else if (!arg_phase_q) begin
            arg_phase_d = 1'b1;
            tx_byte_d   = {5'b0, led_snap_q};
            state_d     = ST_SEND;
          end else begin
            state_d = ST_FINISH;
          end
        end else if (bus.rx_valid && (bus.rx_byte == RSP_RESEND)) begin
          fail = 1'b1;
        end else if (timer_expired) begin
          fail = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        timer_en    = 1'b1;
        timer_limit = bat_timeout;
        if (bus.rx_valid && (bus.rx_byte == RSP_BAT_OK)) begin
          state_d = ST_FINISH;
        end else if (bus.rx_valid && (bus.rx_byte == RSP_BAT_FAIL)) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A failed attempt resends the byte still held in tx_byte_q
    if (fail) begin
      if (retry_q < max_retry) begin
        retry_d = retry_q + 2'd1;
        state_d = ST_SEND;
      end else begin
        error_d = 1'b1;
        state_d = ST_FINISH;
      end
    end
  end

  assign timer_clear = (state_d != state_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_rst_q <= 1'b0;
      pending_led_q <= 1'b0;
      cmd_rst_q     <= 1'b0;
      arg_phase_q   <= 1'b0;
      led_snap_q    <= 3'b0;
      retry_q       <= 2'd0;
      error_q       <= 1'b0;
      tx_byte_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      pending_rst_q <= pending_rst_d;
      pending_led_q <= pending_led_d;
      cmd_rst_q     <= cmd_rst_d;
      arg_phase_q   <= arg_phase_d;
      led_snap_q    <= led_snap_d;
      retry_q       <= retry_d;
      error_q       <= error_d;
      tx_byte_q     <= tx_byte_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign rx_swallow    = busy;
  assign error         = error_q;
  assign bus.tx_start  = (state_q == ST_SEND);
  assign bus.tx_byte   = tx_byte_q;
  assign kb_reset_done = (state_q == ST_FINISH) &&  cmd_rst_q;
  assign led_done      = (state_q == ST_FINISH) && !cmd_rst_q;

endmodule

// File: tb/tb_ps2_kb_command_sequencer.sv
// Scenario bench: expected tx bytes and done pulses are queued with the stimulus and checked by a monitor.
module tb_ps2_kb_command_sequencer;
  import ps2_kb_pkg::*;

  localparam logic [23:0] ACK_TO = 24'd100;
  localparam logic [23:0] BAT_TO = 24'd300;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       kb_reset_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_state = 3'b000;
  logic       kb_reset_done, led_done, error, busy, rx_swallow;

  ps2_kb_command_sequencer_if bus();

  ps2_kb_command_sequencer #(
    .ack_timeout (ACK_TO),
    .bat_timeout (BAT_TO),
    .max_retry   (2'd3)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .kb_reset_req  (kb_reset_req),
    .led_req       (led_req),
    .led_state     (led_state),
    .kb_reset_done (kb_reset_done),
    .led_done      (led_done),
    .error         (error),
    .busy          (busy),
    .rx_swallow    (rx_swallow),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int done_cyc = 0;

  logic [7:0] exp_tx_q[$];
  bit         exp_done_q[$];  // 1 = kb_reset_done, 0 = led_done
  logic [7:0] mon_tx_exp;
  bit         mon_done_exp;

  // Monitor: every tx_start and done pulse must match the head of its expectation queue
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.tx_start) begin
        n_cmp++;
        if (exp_tx_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_byte_unexpected: got %02h, required no transmission", bus.tx_byte);
        end else begin
          mon_tx_exp = exp_tx_q.pop_front();
          if (bus.tx_byte !== mon_tx_exp) begin
            n_err++;
            $display("FAIL tx_byte: got %02h, required %02h", bus.tx_byte, mon_tx_exp);
          end
        end
      end
      if (kb_reset_done || led_done) begin
        n_cmp++;
        if (exp_done_q.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected: got rst=%0b led=%0b, required none", kb_reset_done, led_done);
        end else begin
          mon_done_exp = exp_done_q.pop_front();
          if ({kb_reset_done, led_done} !== {mon_done_exp, !mon_done_exp}) begin
            n_err++;
            $display("FAIL done_kind: got rst=%0b led=%0b, required rst=%0b led=%0b",
                     kb_reset_done, led_done, mon_done_exp, !mon_done_exp);
          end
        end
      end
    end
  end

  task automatic pulse_req(input bit rst, input bit led);
    kb_reset_req = rst;
    led_req      = led;
    @(negedge clock);
    kb_reset_req = 1'b0;
    led_req      = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (bus.tx_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_tx_start: got no tx_start within 500 cycles, required a tx_start", tag);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_idle: got busy for 1000 cycles, required return to idle", tag);
    end
  endtask

  // Called at the negedge where tx_start is seen: transmitter finishes one cycle later
  task automatic answer_tx();
    @(negedge clock);
    bus.tx_done = 1'b1;
    done_cyc    = cyc;
    @(negedge clock);
    bus.tx_done = 1'b0;
  endtask

  task automatic fail_tx();
    @(negedge clock);
    bus.tx_error = 1'b1;
    @(negedge clock);
    bus.tx_error = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clock);
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    got = {busy, rx_swallow, bus.tx_start, error, kb_reset_done, led_done, bus.tx_byte};
    n_cmp++;
    if (got !== 14'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %04h, required 0000", got);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_led_path();
    exp_tx_q.push_back(CMD_SET_LED);
    exp_tx_q.push_back(8'h05);
    exp_done_q.push_back(1'b0);
    led_state = 3'b101;
    pulse_req(1'b0, 1'b1);
    wait_start("led_cmd");
    led_state = 3'b010;  // changed after grant; snapshot must still send 05
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL led_busy_cmd: got %0b, required 1", busy);
    end
    answer_tx();
    send_rx(RSP_ACK);
    wait_start("led_arg");
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL led_busy_arg: got %0b, required 1", busy);
    end
    answer_tx();
    send_rx(RSP_ACK);
    wait_idle("led");
    n_cmp++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL led_error: got %0b, required 0", error);
    end
  endtask

  task automatic test_resend();
    exp_tx_q.push_back(CMD_RESET);
    exp_tx_q.push_back(CMD_RESET);
    exp_done_q.push_back(1'b1);
    pulse_req(1'b1, 1'b0);
    wait_start("resend_1");
    answer_tx();
    send_rx(RSP_RESEND);
    wait_start("resend_2");
    answer_tx();
    send_rx(RSP_ACK);
    send_rx(RSP_BAT_OK);
    wait_idle("resend");
    n_cmp++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL resend_error: got %0b, required 0", error);
    end
  endtask

  task automatic test_timeout();
    int gap;
    for (int i = 0; i < 4; i++) exp_tx_q.push_back(CMD_SET_LED);
    exp_done_q.push_back(1'b0);
    led_state = 3'b001;
    pulse_req(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_start("timeout");
      if (i > 0) begin
        gap = cyc - done_cyc;
        n_cmp++;
        // ack_timeout cycles in WAIT_ACK, plus the cycle tx_done is consumed
        if (gap !== int'(ACK_TO) + 1) begin
          n_err++;
          $display("FAIL timeout_gap: got %0d cycles, required %0d", gap, int'(ACK_TO) + 1);
        end
      end
      answer_tx();
    end
    wait_idle("timeout");
    n_cmp++;
    if (error !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_error: got %0b, required 1", error);
    end
  endtask

  task automatic test_contention();
    exp_tx_q.push_back(CMD_RESET);
    exp_tx_q.push_back(CMD_SET_LED);
    exp_tx_q.push_back(8'h06);
    exp_done_q.push_back(1'b1);
    exp_done_q.push_back(1'b0);
    led_state = 3'b110;
    pulse_req(1'b1, 1'b1);
    wait_start("cont_rst");
    answer_tx();
    send_rx(RSP_ACK);
    send_rx(RSP_BAT_OK);
    wait_start("cont_led");
    answer_tx();
    send_rx(RSP_ACK);
    wait_start("cont_arg");
    answer_tx();
    send_rx(RSP_ACK);
    wait_idle("cont");
    n_cmp++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL cont_error: got %0b, required 0", error);
    end
  endtask

  task automatic test_bat_fail();
    exp_tx_q.push_back(CMD_RESET);
    exp_done_q.push_back(1'b1);
    pulse_req(1'b1, 1'b0);
    wait_start("bat");
    answer_tx();
    n_cmp++;
    if (rx_swallow !== 1'b1) begin
      n_err++;
      $display("FAIL bat_swallow: got %0b, required 1", rx_swallow);
    end
    send_rx(8'h1C);
    n_cmp++;
    if ({busy, bus.tx_start} !== 2'b10) begin
      n_err++;
      $display("FAIL bat_stray: got busy/tx_start %02b, required 10", {busy, bus.tx_start});
    end
    send_rx(RSP_ACK);
    send_rx(RSP_BAT_FAIL);
    wait_idle("bat");
    n_cmp++;
    if (error !== 1'b1) begin
      n_err++;
      $display("FAIL bat_error: got %0b, required 1", error);
    end
  endtask

  task automatic test_reset_mid_op();
    exp_tx_q.push_back(CMD_SET_LED);
    pulse_req(1'b0, 1'b1);
    wait_start("mid");
    answer_tx();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if ({busy, bus.tx_start, error} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_reset: got busy/tx_start/error %03b, required 000", {busy, bus.tx_start, error});
    end
    repeat (10) @(negedge clock);
    // Follow-up LED command; first transmit attempt fails and is retried
    exp_tx_q.push_back(CMD_SET_LED);
    exp_tx_q.push_back(CMD_SET_LED);
    exp_tx_q.push_back(8'h03);
    exp_done_q.push_back(1'b0);
    led_state = 3'b011;
    pulse_req(1'b0, 1'b1);
    wait_start("mid_txerr");
    fail_tx();
    wait_start("mid_cmd");
    answer_tx();
    send_rx(RSP_ACK);
    wait_start("mid_arg");
    answer_tx();
    send_rx(RSP_ACK);
    wait_idle("mid");
    n_cmp++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL mid_error: got %0b, required 0", error);
    end
  endtask

  initial begin
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    @(negedge clock);
    test_reset();
    test_led_path();
    test_resend();
    test_timeout();
    test_reset();
    test_contention();
    test_bat_fail();
    test_reset_mid_op();
    repeat (5) @(negedge clock);
    n_cmp++;
    if (exp_tx_q.size() !== 0) begin
      n_err++;
      $display("FAIL tx_left: got %0d outstanding bytes, required 0", exp_tx_q.size());
    end
    n_cmp++;
    if (exp_done_q.size() !== 0) begin
      n_err++;
      $display("FAIL done_left: got %0d outstanding pulses, required 0", exp_done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
